// File: rtl/core_seq_param_if.sv
// core_seq_param_if
// Bus bundle for one sequencer core: the instruction-fetch handshake to the
// external instruction RAM plus the result output strobe.
//   imem_req   core -> ram   fetch request, high for the whole fetch
//   imem_addr  core -> ram   fetch address (the core PC)
//   imem_ack   ram  -> core  instruction word valid this cycle
//   imem_data  ram  -> core  16-bit instruction word
//   out_valid  core -> sink  one-cycle result strobe
//   out_data   core -> sink  result value, held between strobes
// Modports: master = core side, slave = memory / result consumer side.
interface core_seq_param_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data,
    output out_valid,
    output out_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/core_seq_param.sv
// core_seq_param
// Parametrised multicycle sequencer core: fetches 16-bit instructions over a
// req/ack handshake, executes them against a small register file with a
// single zero flag, and emits results on a registered one-cycle strobe.
//
// Optional feature macro: CORE_SEQ_MUL_EN
//   defined   -> opcode 7 is MUL (combinational multiplier, updates Z)
//   undefined -> no multiplier; opcode 7 is a NOP
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      begin execution at PC 0 (only from IDLE or DONE)
//   bus        core_seq_param_if.master (fetch handshake + output strobe)
//   done       high while in DONE
//   err        high while in ERROR (sticky until reset)
//   pc_out     current PC (debug)
//   state_out  encoded FSM state (debug)
//
// state  | meaning
// IDLE   | after reset, waiting for start
// FETCH  | imem_req high, waiting for imem_ack; IR latched and PC+1 on ack
// EXEC   | execute IR; register/Z/PC/out updates on the closing edge
// DONE   | END executed; registers kept, start restarts at PC 0
// ERROR  | illegal opcode E executed; only reset leaves
module core_seq_param #(
  parameter int DATA_W  = 16,
  parameter int NREG    = 8,
  parameter int PC_W    = 8,
  parameter int CORE_ID = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  core_seq_param_if.master bus,
  output logic             done,
  output logic             err,
  output logic [PC_W-1:0]  pc_out,
  output logic [2:0]       state_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_MOV = 4'h2;
  localparam logic [3:0] OP_INC = 4'h3;
  localparam logic [3:0] OP_CLR = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_MUL = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_JNZ = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;
  localparam logic [3:0] OP_OUT = 4'hC;
  localparam logic [3:0] OP_CID = 4'hD;
  localparam logic [3:0] OP_ILL = 4'hE;
  localparam logic [3:0] OP_END = 4'hF;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              z_q, z_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  logic [3:0]        op;
  logic [3:0]        rd_idx;
  logic [3:0]        rs_idx;
  logic [7:0]        imm8;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] inc_res;
  logic [DATA_W-1:0] add_res;
  logic [DATA_W-1:0] sub_res;
  logic              wr_en;
  logic [DATA_W-1:0] wr_val;
`ifdef CORE_SEQ_MUL_EN
  logic [DATA_W-1:0] mul_res;
`endif

  assign op     = ir_q[15:12];
  assign rd_idx = ir_q[11:8];
  assign rs_idx = ir_q[7:4];
  assign imm8   = ir_q[7:0];

  // Register read ports. Indices at or above NREG match no entry and read 0.
  always_comb begin
    rd_val = '0;
    rs_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rd_idx == 4'(i)) rd_val = regs_q[i];
      if (rs_idx == 4'(i)) rs_val = regs_q[i];
    end
  end

  assign inc_res = rd_val + DATA_W'(1);
  assign add_res = rd_val + rs_val;
  assign sub_res = rd_val - rs_val;
`ifdef CORE_SEQ_MUL_EN
  // DATA_W-wide target keeps only the low half of the product.
  assign mul_res = rd_val * rs_val;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    z_d         = z_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    wr_en       = 1'b0;
    wr_val      = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end

      S_FETCH: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_NOP: ;
          OP_LDI: begin
            wr_en  = 1'b1;
            wr_val = DATA_W'(imm8);
          end
          OP_MOV: begin
            wr_en  = 1'b1;
            wr_val = rs_val;
          end
          OP_INC: begin
            wr_en  = 1'b1;
            wr_val = inc_res;
            z_d    = (inc_res == '0);
          end
          OP_CLR: begin
            wr_en  = 1'b1;
            wr_val = '0;
          end
          OP_ADD: begin
            wr_en  = 1'b1;
            wr_val = add_res;
            z_d    = (add_res == '0);
          end
          OP_SUB: begin
            wr_en  = 1'b1;
            wr_val = sub_res;
            z_d    = (sub_res == '0);
          end
          OP_MUL: begin
`ifdef CORE_SEQ_MUL_EN
            wr_en  = 1'b1;
            wr_val = mul_res;
            z_d    = (mul_res == '0);
`endif
          end
          OP_JZ: begin
            if (z_q) pc_d = PC_W'(imm8);
          end
          OP_JNZ: begin
            if (!z_q) pc_d = PC_W'(imm8);
          end
          OP_JMP: pc_d = PC_W'(imm8);
          OP_CMP: z_d = (rd_val == rs_val);
          OP_OUT: begin
            out_valid_d = 1'b1;
            out_data_d  = rs_val;
          end
          OP_CID: begin
            wr_en  = 1'b1;
            wr_val = DATA_W'(CORE_ID);
          end
          OP_ILL: state_d = S_ERROR;
          OP_END: state_d = S_DONE;
          default: ;
        endcase
      end

      S_ERROR: ;

      default: state_d = S_IDLE;
    endcase
  end

  // Register write port. Out-of-range rd matches no entry, so the write drops.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = (wr_en && (rd_idx == 4'(i))) ? wr_val : regs_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      z_q         <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      regs_q      <= regs_d;
    end
  end

  // Decoded straight from the state register so reset drops them at once.
  assign bus.imem_req  = (state_q == S_FETCH);
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign done          = (state_q == S_DONE);
  assign err           = (state_q == S_ERROR);
  assign pc_out        = pc_q;
  assign state_out     = state_q;

endmodule

// File: doc/core_seq_param.md
# core_seq_param

Parametrised single-core sequencer: a self-contained multicycle core with its own fetch/execute state machine, register file, flag and ALU, replacing the hard-wired control sequence and fixed 16-bit datapath of the previous-generation core. It fetches 16-bit instructions from an external instruction RAM over a req/ack handshake and emits results on a one-cycle output strobe. It is the per-core building block for the multi-core matrix design; CORE_ID distinguishes instances.

## Interface
- DATA_W, 16, register/ALU datapath width (≥8)
- NREG, 8, number of general registers (2..16)
- PC_W, 8, program counter / instruction address width (≤8)
- CORE_ID, 0, constant returned by CID
- clk  in  1  clock, all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  begin execution at PC=0; honoured only in IDLE or DONE
- imem_req  out  1  fetch request, high throughout FETCH
- imem_addr  out  PC_W  fetch address (= PC)
- imem_ack  in  1  instruction valid this cycle; sampled only in FETCH
- imem_data  in  16  instruction word
- out_valid  out  1  one-cycle strobe from OUT
- out_data  out  DATA_W  value for OUT; holds last value otherwise
- done  out  1  high while in DONE
- err  out  1  high while in ERROR
- pc_out  out  PC_W  current PC (debug)
- state_out  out  3  encoded FSM state (debug)

## Operation
- Instruction: op[15:12], rd[11:8], rs[7:4], imm8[7:0].
- Opcodes: 0 NOP; 1 LDI rd=zext(imm8); 2 MOV rd=rs; 3 INC rd=rd+1; 4 CLR rd=0; 5 ADD rd=rd+rs; 6 SUB rd=rd-rs; 7 MUL rd=low DATA_W bits of rd*rs; 8 JZ PC=imm8 if Z; 9 JNZ PC=imm8 if !Z; A JMP PC=imm8; B CMP Z=(rd==rs), no write; C OUT out_data=rs, strobe; D CID rd=CORE_ID; E illegal; F END.
- Arithmetic modulo 2^DATA_W, no carry. Z updated by INC, ADD, SUB, MUL, CMP only; Z=1 when result (or comparison) is zero/equal.
- Register index ≥NREG: write ignored, read returns 0.
- Jump targets: imm8 truncated to PC_W. PC increments wrap to 0 past all-ones.
- States: IDLE(0), FETCH(1), EXEC(2), DONE(3), ERROR(4).
- IDLE --start--> FETCH, PC=0. FETCH --ack--> EXEC (IR latched, PC+1). EXEC --> FETCH, except END->DONE, op E->ERROR. DONE --start--> FETCH with PC=0; registers and Z retained. ERROR is sticky until reset.
- start outside IDLE/DONE ignored; imem_ack outside FETCH ignored.

## Timing
- Reset values: state IDLE, PC 0, all registers 0, Z 0, imem_req 0, imem_addr 0, out_valid 0, out_data 0, done 0, err 0.
- Reset mid-fetch drops imem_req asynchronously; fetch abandoned, no register written.
- imem_req/imem_addr stable from FETCH entry until the ack cycle; ack in the first FETCH cycle permitted. Minimum 2 cycles per instruction (1 FETCH + 1 EXEC); each ack wait cycle adds 1.
- Register, Z, PC (jump) and out_data updates at the rising edge ending EXEC; out_valid registered, high exactly the following cycle.
- done/err rise the cycle after the EXEC of END/op E. start while done=1 drops done next cycle.

## Configuration
- CORE_SEQ_MUL_EN defined: opcode 7 performs MUL (single-cycle combinational multiplier, updates Z).
- Undefined: no multiplier synthesised; opcode 7 behaves as NOP (no register or Z change).

## Test plan
- Reset, start; program LDI r1,5; LDI r2,3; ADD r1,r2; OUT r1; END with 0-wait ack -> out_valid one cycle, out_data=8; done after exactly 10 cycles from first FETCH.
- Loop: LDI r1,0; LDI r2,4; INC r1; CMP r1,r2; JNZ 2; OUT r1; END -> single OUT with 4; DATA_W=8, LDI r1,255; INC r1 -> r1=0, Z=1.
- ack delayed 3 cycles per fetch -> imem_req/addr held stable, each instruction takes 5 cycles, results unchanged.
- MUL r1(=6),r2(=7): with CORE_SEQ_MUL_EN -> OUT 42; without -> OUT 6.
- Opcode E fetched -> err=1, imem_req stays 0, start ignored; reset mid-FETCH -> all outputs return to reset values immediately.
- CID r3 with CORE_ID=5, OUT r3 -> 5; write to r9 with NREG=8 -> ignored, OUT r9 returns 0.
